cc_orientation_debouncer: RTL and testbench

//  Parametrised successor of the CC1/CC2 orientation FSM in the Type-C authentication driver.

---
 rtl/cc_orientation_debouncer.sv | 151 +++++++++++++++
 tb/tb_cc_orientation_debouncer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cc_orientation_debouncer.sv
// Debounces CC1/CC2 attach/detach, locks plug orientation until detach and drives TX2 lane select.
// Outputs are registered or decoded from registered state only; no combinational path from cc1/cc2.
module cc_orientation_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DETACH_CYCLES   = 8,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic cc1,
    input  logic cc2,
    output logic attached,
    output logic orient,
    output logic attach_pulse,
    output logic detach_pulse,
    output logic fault,
    output logic tx2_m,
    output logic tx2_p
);

    typedef enum logic [4:0] {
        IDLE        = 5'b00001,
        DEBOUNCE    = 5'b00010,
        ATTACHED    = 5'b00100,
        DETACH_WAIT = 5'b01000,
        FAULT       = 5'b10000
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DET_LAST = CNT_W'(DETACH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cand_q, cand_d;
    logic             orient_q, orient_d;
    logic             attach_pulse_q, attach_pulse_d;
    logic             detach_pulse_q, detach_pulse_d;

    logic cand_hi;
    logic other_hi;
    logic in_attached;

    assign cand_hi     = cand_q ? cc2 : cc1;
    assign other_hi    = cand_q ? cc1 : cc2;
    assign in_attached = (state_q == ATTACHED) || (state_q == DETACH_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            cand_q         <= 1'b0;
            orient_q       <= 1'b0;
            attach_pulse_q <= 1'b0;
            detach_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cand_q         <= cand_d;
            orient_q       <= orient_d;
            attach_pulse_q <= attach_pulse_d;
            detach_pulse_q <= detach_pulse_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cand_d         = cand_q;
        orient_d       = orient_q;
        attach_pulse_d = 1'b0;
        detach_pulse_d = 1'b0;

        if (!enable) begin
            // Disabling a live link still reports the detach to the auth FSM.
            state_d        = IDLE;
            cnt_d          = '0;
            detach_pulse_d = in_attached;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cc1 && cc2) begin
                        state_d = FAULT;
                    end else if (cc1) begin
                        state_d = DEBOUNCE;
                        cand_d  = 1'b0;
                        cnt_d   = CNT_ONE;
                    end else if (cc2) begin
                        state_d = DEBOUNCE;
                        cand_d  = 1'b1;
                        cnt_d   = CNT_ONE;
                    end
                end
                DEBOUNCE: begin
                    if (cc1 && cc2) begin
                        state_d = FAULT;
                        cnt_d   = '0;
                    end else if (!cand_hi || other_hi) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d        = ATTACHED;
                        orient_d       = cand_q;
                        attach_pulse_d = 1'b1;
                        cnt_d          = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ATTACHED: begin
                    // The non-candidate line is ignored once orientation is locked.
                    if (!cand_hi) begin
                        state_d = DETACH_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
                DETACH_WAIT: begin
                    if (cand_hi) begin
                        state_d = ATTACHED;
                        cnt_d   = '0;
                    end else if (cnt_q == DET_LAST) begin
                        state_d        = IDLE;
                        detach_pulse_d = 1'b1;
                        cnt_d          = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                FAULT: begin
                    if (!cc1 && !cc2) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign attached     = in_attached;
    assign orient       = orient_q;
    assign attach_pulse = attach_pulse_q;
    assign detach_pulse = detach_pulse_q;
    assign fault        = (state_q == FAULT);
    assign tx2_m        = in_attached & ~orient_q;
    assign tx2_p        = in_attached & orient_q;

endmodule

// File: tb/tb_cc_orientation_debouncer.sv
// Vector-table bench for cc_orientation_debouncer with a queue scoreboard of expected outputs.
module tb_cc_orientation_debouncer;

    logic clk = 1'b0;
    logic reset, enable, cc1, cc2;
    logic attached, orient, attach_pulse, detach_pulse, fault, tx2_m, tx2_p;

    always #5 clk = ~clk;

    cc_orientation_debouncer #(
        .DEBOUNCE_CYCLES(16),
        .DETACH_CYCLES  (8),
        .CNT_W          (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cc1         (cc1),
        .cc2         (cc2),
        .attached    (attached),
        .orient      (orient),
        .attach_pulse(attach_pulse),
        .detach_pulse(detach_pulse),
        .fault       (fault),
        .tx2_m       (tx2_m),
        .tx2_p       (tx2_p)
    );

    typedef struct {
        logic  rst, en, c1, c2;
        int    n;
        logic  att, ori, ap, dp, flt;
        string nm;
    } vec_t;

    // att, ori, ap, dp, flt, tx2_m, tx2_p
    typedef logic [6:0] exp_t;

    vec_t  tbl[$];
    exp_t  sb[$];
    string sb_nm[$];
    int    n_vec  = 0;
    int    n_fail = 0;

    task automatic add(input logic rst, en, c1, c2, input int n,
                       input logic att, ori, ap, dp, flt, input string nm);
        vec_t v;
        v.rst = rst; v.en = en; v.c1 = c1; v.c2 = c2; v.n = n;
        v.att = att; v.ori = ori; v.ap = ap; v.dp = dp; v.flt = flt; v.nm = nm;
        tbl.push_back(v);
    endtask

    // Drive one cycle of stimulus, queue its expectation, and check after the edge.
    task automatic step(input vec_t v, input int idx);
        exp_t e, got, want;
        string nm;
        @(negedge clk);
        reset = v.rst; enable = v.en; cc1 = v.c1; cc2 = v.c2;
        e = {v.att, v.ori, v.ap, v.dp, v.flt, v.att & ~v.ori, v.att & v.ori};
        sb.push_back(e);
        sb_nm.push_back($sformatf("%s[%0d]", v.nm, idx));
        @(posedge clk);
        #1;
        got  = {attached, orient, attach_pulse, detach_pulse, fault, tx2_m, tx2_p};
        want = sb.pop_front();
        nm   = sb_nm.pop_front();
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got att/ori/ap/dp/flt/tm/tp=%b required %b", nm, got, want);
        end
    endtask

    task automatic run_row(input vec_t v);
        for (int i = 0; i < v.n; i++) step(v, i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        vec_t h;
        reset = 1'b1; enable = 1'b1; cc1 = 1'b0; cc2 = 1'b0;

        //   rst en c1 c2  n  att ori ap dp flt
        add(1, 1, 0, 0, 2,  0, 0, 0, 0, 0, "reset");
        add(0, 1, 0, 0, 3,  0, 0, 0, 0, 0, "idle");
        // T1: attach via CC1 on the 16th sampled edge
        add(0, 1, 1, 0, 15, 0, 0, 0, 0, 0, "t1_debounce");
        add(0, 1, 1, 0, 1,  1, 0, 1, 0, 0, "t1_attach");
        add(0, 1, 1, 0, 3,  1, 0, 0, 0, 0, "t1_hold");
        // T5: CC2 ignored after lock
        add(0, 1, 1, 1, 4,  1, 0, 0, 0, 0, "t5_locked");
        // T3: short drop recovers, full drop detaches on the 8th low edge
        add(0, 1, 0, 0, 5,  1, 0, 0, 0, 0, "t3_short_drop");
        add(0, 1, 1, 0, 2,  1, 0, 0, 0, 0, "t3_recover");
        add(0, 1, 0, 0, 7,  1, 0, 0, 0, 0, "t3_detach_wait");
        add(0, 1, 0, 0, 1,  0, 0, 0, 1, 0, "t3_detach");
        add(0, 1, 0, 0, 2,  0, 0, 0, 0, 0, "t3_idle");
        // T2: glitch restarts debounce; attach via CC2
        add(0, 1, 0, 1, 10, 0, 0, 0, 0, 0, "t2_first_rise");
        add(0, 1, 0, 0, 1,  0, 0, 0, 0, 0, "t2_glitch");
        add(0, 1, 0, 1, 15, 0, 0, 0, 0, 0, "t2_debounce");
        add(0, 1, 0, 1, 1,  1, 1, 1, 0, 0, "t2_attach");
        add(0, 1, 0, 1, 4,  1, 1, 0, 0, 0, "t2_hold");
        add(0, 1, 0, 0, 7,  1, 1, 0, 0, 0, "t2_detach_wait");
        add(0, 1, 0, 0, 1,  0, 1, 0, 1, 0, "t2_detach");
        add(0, 1, 0, 0, 1,  0, 1, 0, 0, 0, "t2_idle");
        // T4: both-high fault, single-high does not exit, both-low clears
        add(0, 1, 1, 1, 1,  0, 1, 0, 0, 1, "t4_fault");
        add(0, 1, 1, 0, 3,  0, 1, 0, 0, 1, "t4_fault_hold");
        add(0, 1, 0, 0, 1,  0, 1, 0, 0, 0, "t4_clear");
        add(0, 1, 1, 0, 15, 0, 1, 0, 0, 0, "t4_debounce");
        add(0, 1, 1, 0, 1,  1, 0, 1, 0, 0, "t4_attach");
        // T6: enable drop while attached emits one detach pulse
        add(0, 0, 1, 0, 1,  0, 0, 0, 1, 0, "t6_disable");
        add(0, 0, 1, 0, 2,  0, 0, 0, 0, 0, "t6_disabled");
        add(0, 1, 0, 1, 15, 0, 0, 0, 0, 0, "t6_debounce");
        add(0, 1, 0, 1, 1,  1, 1, 1, 0, 0, "t6_attach");
        add(0, 1, 0, 1, 2,  1, 1, 0, 0, 0, "t6_hold");
        add(1, 1, 0, 1, 1,  0, 0, 0, 0, 0, "t6_reset");
        add(0, 1, 0, 0, 2,  0, 0, 0, 0, 0, "t6_after_reset");
        // Fault from DEBOUNCE, and enable=0 clears FAULT
        add(0, 1, 1, 0, 3,  0, 0, 0, 0, 0, "deb_partial");
        add(0, 1, 1, 1, 1,  0, 0, 0, 0, 1, "deb_fault");
        add(0, 0, 1, 1, 1,  0, 0, 0, 0, 0, "fault_disable");
        add(0, 1, 0, 0, 1,  0, 0, 0, 0, 0, "fault_gone");

        foreach (tbl[i]) run_row(tbl[i]);

        // Hand sequence: reset while in DETACH_WAIT aborts with no pulse.
        h.en = 1; h.ap = 0; h.dp = 0; h.flt = 0; h.ori = 0;
        h.rst = 0; h.c1 = 1; h.c2 = 0;
        h.att = 0; h.n = 15; h.nm = "hs_debounce"; run_row(h);
        h.att = 1; h.ap = 1; h.n = 1; h.nm = "hs_attach"; run_row(h);
        h.ap = 0; h.c1 = 0; h.n = 3; h.nm = "hs_detach_wait"; run_row(h);
        h.rst = 1; h.att = 0; h.n = 1; h.nm = "hs_reset"; run_row(h);
        h.rst = 0; h.n = 10; h.nm = "hs_quiet"; run_row(h);

        // Hand sequence: reset in mid-debounce restarts the full count.
        h.c1 = 1; h.n = 8; h.nm = "hs2_partial"; run_row(h);
        h.rst = 1; h.n = 1; h.nm = "hs2_reset"; run_row(h);
        h.rst = 0; h.n = 15; h.nm = "hs2_debounce"; run_row(h);
        h.att = 1; h.ap = 1; h.n = 1; h.nm = "hs2_attach"; run_row(h);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
